knn_stream_classifier: RTL and testbench

- Parametrised successor of the fixed 2-D, 16-unit KNN peripheral core. Classifies one test point against a streamed dataset.
- Supports N_DIMS signed coordinates, configurable K and class width, and a valid/ready input stream.
- Runs a pipelined squared-distance calculation and keeps a sorted top-K list.
- Ends with a majority vote. Sits behind the KNN register bank; one instance per test point.

---
 rtl/knn_pkg.sv | 27 ++
 rtl/knn_dist_pipe.sv | 84 ++++++++
 rtl/knn_stream_classifier.sv | 208 ++++++++++++++++++++
 tb/tb_knn_stream_classifier.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// Shared definitions for the streaming KNN classifier: controller states,
// distance width formula, pipeline depth and class-count helper.
package knn_pkg;

  // Controller states of one classification query
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_DRAIN,
    ST_VOTE,
    ST_DONE
  } state_t;

  // Depth of the squared-distance pipeline in cycles
  localparam int PIPE_LAT = 3;

  // Width of a sum of N_DIMS squared (COORD_W+1)-bit differences
  function automatic int dist_width(input int coord_w, input int n_dims);
    return 2 * coord_w + 2 + $clog2(n_dims);
  endfunction

  // Number of distinct class labels representable in class_w bits
  function automatic int num_classes(input int class_w);
    return 1 << class_w;
  endfunction

endpackage

// File: rtl/knn_dist_pipe.sv
// Three-stage squared Euclidean distance pipeline. The class label and a
// valid bit travel alongside the data so the output is self-describing.
module knn_dist_pipe
  import knn_pkg::*;
#(
  parameter int COORD_W = 16,
  parameter int N_DIMS  = 2,
  parameter int CLASS_W = 3,
  localparam int DIST_W = dist_width(COORD_W, N_DIMS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [N_DIMS*COORD_W-1:0]   in_coords,
  input  logic [N_DIMS*COORD_W-1:0]   test_coords,
  input  logic [CLASS_W-1:0]          in_class,
  output logic                        out_valid,
  output logic [DIST_W-1:0]           out_dist,
  output logic [CLASS_W-1:0]          out_class,
  output logic                        active
);

  localparam int DIFF_W = COORD_W + 1;
  localparam int SQ_W   = 2 * COORD_W + 2;

  logic [PIPE_LAT-1:0] vld;
  logic [CLASS_W-1:0]  cls1, cls2, cls3;
  logic [DIFF_W-1:0]   diff_d [N_DIMS];
  logic [DIFF_W-1:0]   diff_q [N_DIMS];
  logic [SQ_W-1:0]     sq_d   [N_DIMS];
  logic [SQ_W-1:0]     sq_q   [N_DIMS];
  logic [DIST_W-1:0]   sum_d;
  logic [DIST_W-1:0]   dist_q;

  // Per-dimension difference; sign-extending both operands by one bit makes
  // the modular subtraction exact for any pair of signed coordinates
  always_comb begin
    for (int d = 0; d < N_DIMS; d++) begin
      diff_d[d] = {in_coords[d*COORD_W+COORD_W-1], in_coords[d*COORD_W +: COORD_W]}
                - {test_coords[d*COORD_W+COORD_W-1], test_coords[d*COORD_W +: COORD_W]};
    end
  end

  // Square of each sign-extended difference; the true square always fits SQ_W
  always_comb begin
    for (int d = 0; d < N_DIMS; d++) begin
      sq_d[d] = {{(SQ_W-DIFF_W){diff_q[d][DIFF_W-1]}}, diff_q[d]}
              * {{(SQ_W-DIFF_W){diff_q[d][DIFF_W-1]}}, diff_q[d]};
    end
  end

  // Sum of squares across dimensions; DIST_W leaves room for every carry
  always_comb begin
    sum_d = '0;
    for (int d = 0; d < N_DIMS; d++) begin
      sum_d = sum_d + DIST_W'(sq_q[d]);
    end
  end

  // Valid bits shift through the stages; cleared by reset only
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld <= {vld[PIPE_LAT-2:0], in_valid};
    end
  end

  // Data and class registers for all three stages
  always_ff @(posedge clk) begin
    diff_q <= diff_d;
    cls1   <= in_class;
    sq_q   <= sq_d;
    cls2   <= cls1;
    dist_q <= sum_d;
    cls3   <= cls2;
  end

  assign out_valid = vld[PIPE_LAT-1];
  assign out_dist  = dist_q;
  assign out_class = cls3;
  assign active    = |vld;

endmodule

// File: rtl/knn_stream_classifier.sv
// Streaming k-nearest-neighbour classifier: accepts dataset beats, keeps a
// sorted top-K list of nearest points and majority-votes their labels.
module knn_stream_classifier
  import knn_pkg::*;
#(
  parameter int COORD_W = 16,
  parameter int N_DIMS  = 2,
  parameter int K       = 4,
  parameter int CLASS_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_test,
  input  logic [N_DIMS*COORD_W-1:0]   test_point,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [N_DIMS*COORD_W-1:0]   s_coords,
  input  logic [CLASS_W-1:0]          s_class,
  input  logic                        finish,
  output logic                        busy,
  output logic                        done,
  output logic [CLASS_W-1:0]          result_class,
  output logic                        result_empty,
  output logic [CNT_W-1:0]            num_seen
);

  localparam int DIST_W    = dist_width(COORD_W, N_DIMS);
  localparam int N_CLASSES = num_classes(CLASS_W);
  localparam int VCNT_W    = $clog2(K + 1);

  state_t state_q, state_d;

  logic                      start_query;
  logic                      beat;
  logic [N_DIMS*COORD_W-1:0] test_q;

  logic                      pipe_valid;
  logic [DIST_W-1:0]         pipe_dist;
  logic [CLASS_W-1:0]        pipe_class;
  logic                      pipe_active;

  logic                      slot_valid [K];
  logic [DIST_W-1:0]         slot_dist  [K];
  logic [CLASS_W-1:0]        slot_class [K];
  logic                      next_valid [K];
  logic [DIST_W-1:0]         next_dist  [K];
  logic [CLASS_W-1:0]        next_class [K];
  logic                      gt         [K];

  logic [CLASS_W-1:0]        vote_idx;
  logic [CLASS_W-1:0]        best_class;
  logic [VCNT_W-1:0]         best_count;
  logic [VCNT_W-1:0]         cur_count;
  logic                      vote_last;

  assign start_query = load_test && (state_q == ST_IDLE || state_q == ST_DONE);
  assign s_ready     = (state_q == ST_ACCEPT);
  assign beat        = s_valid && s_ready;
  assign busy        = (state_q == ST_ACCEPT) || (state_q == ST_DRAIN) || (state_q == ST_VOTE);
  assign done        = (state_q == ST_DONE);
  assign vote_last   = (vote_idx == CLASS_W'(N_CLASSES - 1));

  knn_dist_pipe #(
    .COORD_W (COORD_W),
    .N_DIMS  (N_DIMS),
    .CLASS_W (CLASS_W)
  ) u_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (beat),
    .in_coords   (s_coords),
    .test_coords (test_q),
    .in_class    (s_class),
    .out_valid   (pipe_valid),
    .out_dist    (pipe_dist),
    .out_class   (pipe_class),
    .active      (pipe_active)
  );

  // Controller state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; load_test and finish only matter in their own states
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (load_test)    state_d = ST_ACCEPT;
      ST_ACCEPT: if (finish)       state_d = ST_DRAIN;
      ST_DRAIN:  if (!pipe_active) state_d = ST_VOTE;
      ST_VOTE:   if (vote_last)    state_d = ST_DONE;
      ST_DONE:   if (load_test)    state_d = ST_ACCEPT;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // Test point is captured once per query and held for the whole stream
  always_ff @(posedge clk) begin
    if (rst) begin
      test_q <= '0;
    end else if (start_query) begin
      test_q <= test_point;
    end
  end

  // Saturating count of accepted dataset beats
  always_ff @(posedge clk) begin
    if (rst || start_query) begin
      num_seen <= '0;
    end else if (beat && num_seen != {CNT_W{1'b1}}) begin
      num_seen <= num_seen + CNT_W'(1);
    end
  end

  // Sorted insertion: invalid slots act as +infinity and equal distances keep
  // the earlier arrival nearer, so the entry lands at the first strictly
  // farther slot and everything behind it shifts down, dropping slot K-1
  always_comb begin
    for (int k = 0; k < K; k++) begin
      gt[k]         = !slot_valid[k] || (slot_dist[k] > pipe_dist);
      next_valid[k] = slot_valid[k];
      next_dist[k]  = slot_dist[k];
      next_class[k] = slot_class[k];
    end
    if (gt[0]) begin
      next_valid[0] = 1'b1;
      next_dist[0]  = pipe_dist;
      next_class[0] = pipe_class;
    end
    for (int k = 1; k < K; k++) begin
      if (gt[k]) begin
        if (gt[k-1]) begin
          next_valid[k] = slot_valid[k-1];
          next_dist[k]  = slot_dist[k-1];
          next_class[k] = slot_class[k-1];
        end else begin
          next_valid[k] = 1'b1;
          next_dist[k]  = pipe_dist;
          next_class[k] = pipe_class;
        end
      end
    end
  end

  // Top-K list register, updated once per distance leaving the pipeline
  always_ff @(posedge clk) begin
    if (rst || start_query) begin
      for (int k = 0; k < K; k++) begin
        slot_valid[k] <= 1'b0;
        slot_dist[k]  <= '0;
        slot_class[k] <= '0;
      end
    end else if (pipe_valid) begin
      slot_valid <= next_valid;
      slot_dist  <= next_dist;
      slot_class <= next_class;
    end
  end

  // Number of list entries carrying the class currently being tallied
  always_comb begin
    cur_count = '0;
    for (int k = 0; k < K; k++) begin
      if (slot_valid[k] && slot_class[k] == vote_idx) begin
        cur_count = cur_count + VCNT_W'(1);
      end
    end
  end

  // Class-by-class vote; only a strictly larger tally replaces the leader so
  // ties resolve to the lowest class index
  always_ff @(posedge clk) begin
    if (rst || start_query) begin
      vote_idx     <= '0;
      best_class   <= '0;
      best_count   <= '0;
      result_class <= '0;
      result_empty <= 1'b0;
    end else if (state_q == ST_DRAIN) begin
      vote_idx   <= '0;
      best_class <= '0;
      best_count <= '0;
    end else if (state_q == ST_VOTE) begin
      vote_idx <= vote_idx + CLASS_W'(1);
      if (cur_count > best_count) begin
        best_count <= cur_count;
        best_class <= vote_idx;
      end
      if (vote_last) begin
        result_empty <= !slot_valid[0];
        if (!slot_valid[0]) begin
          result_class <= '0;
        end else if (cur_count > best_count) begin
          result_class <= vote_idx;
        end else begin
          result_class <= best_class;
        end
      end
    end
  end

endmodule

// File: tb/tb_knn_stream_classifier.sv
// Directed bench for knn_stream_classifier: a K=4 instance and a K=1 instance
// with a 2-bit beat counter share the same stimulus.
module tb_knn_stream_classifier;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_test;
  logic [31:0] test_point;
  logic        s_valid;
  logic [31:0] s_coords;
  logic [2:0]  s_class;
  logic        finish;

  logic        s_ready, busy, done, result_empty;
  logic [2:0]  result_class;
  logic [15:0] num_seen;

  logic        s_ready1, busy1, done1, result_empty1;
  logic [2:0]  result_class1;
  logic [1:0]  num_seen1;

  int checks   = 0;
  int failures = 0;
  int cyc;

  knn_stream_classifier #(.COORD_W(16), .N_DIMS(2), .K(4), .CLASS_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .load_test(load_test), .test_point(test_point),
    .s_valid(s_valid), .s_ready(s_ready), .s_coords(s_coords), .s_class(s_class),
    .finish(finish), .busy(busy), .done(done), .result_class(result_class),
    .result_empty(result_empty), .num_seen(num_seen)
  );

  knn_stream_classifier #(.COORD_W(16), .N_DIMS(2), .K(1), .CLASS_W(3), .CNT_W(2)) dut_k1 (
    .clk(clk), .rst(rst), .load_test(load_test), .test_point(test_point),
    .s_valid(s_valid), .s_ready(s_ready1), .s_coords(s_coords), .s_class(s_class),
    .finish(finish), .busy(busy1), .done(done1), .result_class(result_class1),
    .result_empty(result_empty1), .num_seen(num_seen1)
  );

  // Free-running 10-time-unit clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pt(input int x, input int y);
    return {16'(y), 16'(x)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic startQuery(input int x, input int y);
    test_point = pt(x, y);
    load_test  = 1'b1;
    step();
    load_test  = 1'b0;
  endtask

  task automatic applyStimulus(input int x, input int y, input int c);
    s_coords = pt(x, y);
    s_class  = 3'(c);
    s_valid  = 1'b1;
    step();
    s_valid  = 1'b0;
  endtask

  task automatic waitDone(output int n);
    n = 1;
    while (!done && n < 40) begin
      step();
      n++;
    end
    checkOutput("done_timeout", {63'd0, done}, 64'd1);
  endtask

  task automatic runVote(output int n);
    finish = 1'b1;
    step();
    finish = 1'b0;
    waitDone(n);
  endtask

  initial begin
    rst = 1'b1; load_test = 1'b0; test_point = '0; s_valid = 1'b0;
    s_coords = '0; s_class = '0; finish = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    $display("[TB] reset state");
    checkOutput("rst_s_ready", {63'd0, s_ready}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_result_class", {61'd0, result_class}, 64'd0);
    checkOutput("rst_result_empty", {63'd0, result_empty}, 64'd0);
    checkOutput("rst_num_seen", {48'd0, num_seen}, 64'd0);
    finish = 1'b1; s_valid = 1'b1; s_coords = pt(1, 1);
    step();
    finish = 1'b0; s_valid = 1'b0;
    step();
    checkOutput("idle_ignore_busy", {63'd0, busy}, 64'd0);
    checkOutput("idle_ignore_num_seen", {48'd0, num_seen}, 64'd0);

    $display("[TB] basic vote");
    startQuery(0, 0);
    checkOutput("accept_s_ready", {63'd0, s_ready}, 64'd1);
    checkOutput("accept_busy", {63'd0, busy}, 64'd1);
    applyStimulus(1, 0, 1);
    applyStimulus(0, 2, 2);
    applyStimulus(3, 3, 5);
    applyStimulus(1, 1, 1);
    applyStimulus(10, 10, 7);
    runVote(cyc);
    checkOutput("basic_latency_le13", {63'd0, (cyc <= 13)}, 64'd1);
    checkOutput("basic_class", {61'd0, result_class}, 64'd1);
    checkOutput("basic_empty", {63'd0, result_empty}, 64'd0);
    checkOutput("basic_num_seen", {48'd0, num_seen}, 64'd5);
    checkOutput("basic_num_seen_sat", {62'd0, num_seen1}, 64'd3);
    checkOutput("basic_k1_class", {61'd0, result_class1}, 64'd1);
    checkOutput("basic_d0", 64'(dut.slot_dist[0]), 64'd1);
    checkOutput("basic_d1", 64'(dut.slot_dist[1]), 64'd2);
    checkOutput("basic_d2", 64'(dut.slot_dist[2]), 64'd4);
    checkOutput("basic_d3", 64'(dut.slot_dist[3]), 64'd18);
    checkOutput("basic_busy_done", {63'd0, busy}, 64'd0);
    finish = 1'b1;
    step();
    finish = 1'b0;
    checkOutput("done_ignores_finish", {63'd0, done}, 64'd1);

    $display("[TB] vote tie, last beat alongside finish");
    startQuery(0, 0);
    checkOutput("tie_done_dropped", {63'd0, done}, 64'd0);
    checkOutput("tie_num_seen_zero", {48'd0, num_seen}, 64'd0);
    applyStimulus(1, 0, 6);
    applyStimulus(1, 1, 3);
    applyStimulus(2, 0, 6);
    s_coords = pt(2, 1); s_class = 3'd3; s_valid = 1'b1; finish = 1'b1;
    step();
    s_valid = 1'b0; finish = 1'b0;
    waitDone(cyc);
    checkOutput("tie_num_seen", {48'd0, num_seen}, 64'd4);
    checkOutput("tie_class", {61'd0, result_class}, 64'd3);
    checkOutput("tie_d3", 64'(dut.slot_dist[3]), 64'd5);

    $display("[TB] distance tie and eviction");
    startQuery(0, 0);
    applyStimulus(2, 0, 4);
    applyStimulus(0, 2, 2);
    applyStimulus(-2, 0, 6);
    applyStimulus(0, -2, 5);
    applyStimulus(2, 0, 7);
    runVote(cyc);
    checkOutput("evict_c0", 64'(dut.slot_class[0]), 64'd4);
    checkOutput("evict_c1", 64'(dut.slot_class[1]), 64'd2);
    checkOutput("evict_c2", 64'(dut.slot_class[2]), 64'd6);
    checkOutput("evict_c3", 64'(dut.slot_class[3]), 64'd5);
    checkOutput("evict_class", {61'd0, result_class}, 64'd2);
    checkOutput("evict_k1_class", {61'd0, result_class1}, 64'd4);

    $display("[TB] signed extremes");
    startQuery(-32768, -32768);
    applyStimulus(32767, 32767, 1);
    applyStimulus(-32768, -32767, 2);
    runVote(cyc);
    checkOutput("ext_d0", 64'(dut.slot_dist[0]), 64'd1);
    checkOutput("ext_d1", 64'(dut.slot_dist[1]), 64'd8589672450);
    checkOutput("ext_v2", 64'(dut.slot_valid[2]), 64'd0);
    checkOutput("ext_k1_class", {61'd0, result_class1}, 64'd2);
    checkOutput("ext_k4_class", {61'd0, result_class}, 64'd1);

    $display("[TB] empty query");
    startQuery(0, 0);
    runVote(cyc);
    checkOutput("empty_flag", {63'd0, result_empty}, 64'd1);
    checkOutput("empty_class", {61'd0, result_class}, 64'd0);
    checkOutput("empty_num_seen", {48'd0, num_seen}, 64'd0);

    $display("[TB] abort and ignored reload");
    startQuery(0, 0);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("abort_s_ready", {63'd0, s_ready}, 64'd0);
    checkOutput("abort_num_seen", {48'd0, num_seen}, 64'd0);
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    startQuery(0, 0);
    applyStimulus(1, 0, 3);
    applyStimulus(2, 0, 3);
    startQuery(5, 5);
    applyStimulus(0, 1, 4);
    checkOutput("reload_num_seen", {48'd0, num_seen}, 64'd3);
    runVote(cyc);
    checkOutput("reload_class", {61'd0, result_class}, 64'd3);
    checkOutput("reload_d0", 64'(dut.slot_dist[0]), 64'd1);
    checkOutput("reload_c1", 64'(dut.slot_class[1]), 64'd4);
    checkOutput("reload_d2", 64'(dut.slot_dist[2]), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
